// File: rtl/fpu_pkg.sv
// Shared binary32 field widths, constants, status bit positions and payload
// types for the FP multiplier output stages.
package fpu_pkg;

  localparam int unsigned SIGN_W   = 1;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned FP_W     = SIGN_W + EXP_W + FRAC_W;
  localparam int unsigned GRS_W    = 3;
  localparam int unsigned STATUS_W = 5;

  localparam logic [EXP_W-1:0] EXP_MAX      = 8'hFF;
  localparam int unsigned      BIAS         = 127;
  localparam logic [FP_W-1:0]  QNAN_PATTERN = 32'h7FC0_0000;

  localparam int unsigned ST_NV = 4;
  localparam int unsigned ST_OF = 3;
  localparam int unsigned ST_UF = 2;
  localparam int unsigned ST_NX = 1;
  localparam int unsigned ST_ZR = 0;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // Rounded product plus the upstream exception flags, carried stage 1 -> 2.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp_r;
    logic [FRAC_W-1:0] mant_r;
    logic              rnd_ovf;
    logic              inexact;
    logic              nv;
    logic              of;
    logic              uf;
    logic              zr;
  } s1_payload_t;

  function automatic logic [STATUS_W-1:0] make_status(
    input logic nv,
    input logic of,
    input logic uf,
    input logic nx,
    input logic zr
  );
    logic [STATUS_W-1:0] st;
    st        = '0;
    st[ST_NV] = nv;
    st[ST_OF] = of;
    st[ST_UF] = uf;
    st[ST_NX] = nx;
    st[ST_ZR] = zr;
    return st;
  endfunction

  function automatic logic [FP_W-1:0] pack_fp(
    input logic              sign,
    input logic [EXP_W-1:0]  exp,
    input logic [FRAC_W-1:0] frac
  );
    fp32_t f;
    f.sign = sign;
    f.exp  = exp;
    f.frac = frac;
    return f;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalized fraction using its guard/round/sticky
// bits; a fraction carry-out bumps the exponent.
module fp_round_rne
  import fpu_pkg::*;
(
  input  logic [FRAC_W-1:0] mant,
  input  logic [EXP_W-1:0]  exp,
  input  logic [GRS_W-1:0]  grs,
  output logic [FRAC_W-1:0] mant_r,
  output logic [EXP_W-1:0]  exp_r,
  output logic              rnd_ovf,
  output logic              inexact
);

  logic             w_guard;
  logic             w_round;
  logic             w_sticky;
  logic             w_round_up;
  logic             w_carry;
  logic [EXP_W:0]   w_exp_wide;

  assign w_guard  = grs[2];
  assign w_round  = grs[1];
  assign w_sticky = grs[0];

  // Ties (G=1, R=S=0) only round up when the kept LSB is odd.
  assign w_round_up = w_guard & (w_round | w_sticky | mant[0]);

  assign {w_carry, mant_r} = {1'b0, mant} + (FRAC_W+1)'(w_round_up);

  // Nine bits wide so an increment past 254 is visible as overflow.
  assign w_exp_wide = {1'b0, exp} + (EXP_W+1)'(w_carry);
  assign exp_r      = w_exp_wide[EXP_W-1:0];
  assign rnd_ovf    = (w_exp_wide >= (EXP_W+1)'(EXP_MAX));

  assign inexact = w_guard | w_round | w_sticky;

endmodule

// File: rtl/fp_mul_round_pack.sv
// FP multiplier output stage: RNE rounding (stage 1) then exception priority
// and binary32 packing (stage 2), behind a 2-deep valid/ready pipeline.
module fp_mul_round_pack
  import fpu_pkg::*;
#(
  parameter logic [FP_W-1:0] QNAN_PATTERN  = fpu_pkg::QNAN_PATTERN,
  parameter bit              FLUSH_TO_ZERO = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                sign_z,
  input  logic [EXP_W-1:0]    exp_z,
  input  logic [FRAC_W-1:0]   mant_z,
  input  logic [GRS_W-1:0]    grs,
  input  logic                invalid_flag,
  input  logic                overflow_flag,
  input  logic                underflow_flag,
  input  logic                zero_flag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FP_W-1:0]     result,
  output logic [STATUS_W-1:0] status
);

  logic                r_s1_valid;
  s1_payload_t         r_s1;
  logic                r_s2_valid;
  logic [FP_W-1:0]     r_result;
  logic [STATUS_W-1:0] r_status;

  logic                w_s1_load;
  logic                w_s2_load;
  logic [FRAC_W-1:0]   w_mant_r;
  logic [EXP_W-1:0]    w_exp_r;
  logic                w_rnd_ovf;
  logic                w_inexact;
  s1_payload_t         w_s1_next;
  logic [FP_W-1:0]     w_result;
  logic [STATUS_W-1:0] w_status;
  logic [FP_W-1:0]     w_inf;
  logic [FP_W-1:0]     w_zero;

  // Each stage may load when it is empty or its contents move on this cycle.
  assign w_s2_load = !r_s2_valid | out_ready;
  assign w_s1_load = !r_s1_valid | w_s2_load;
  assign in_ready  = w_s1_load;

  fp_round_rne u_round (
    .mant    (mant_z),
    .exp     (exp_z),
    .grs     (grs),
    .mant_r  (w_mant_r),
    .exp_r   (w_exp_r),
    .rnd_ovf (w_rnd_ovf),
    .inexact (w_inexact)
  );

  always_comb begin
    w_s1_next         = '0;
    w_s1_next.sign    = sign_z;
    w_s1_next.exp_r   = w_exp_r;
    w_s1_next.mant_r  = w_mant_r;
    w_s1_next.rnd_ovf = w_rnd_ovf;
    w_s1_next.inexact = w_inexact;
    w_s1_next.nv      = invalid_flag;
    w_s1_next.of      = overflow_flag;
    w_s1_next.uf      = underflow_flag;
    w_s1_next.zr      = zero_flag;
  end

  // Stage 1: rounded product and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1 <= w_s1_next;
      end
    end
  end

  assign w_inf  = pack_fp(r_s1.sign, EXP_MAX, '0);
  assign w_zero = pack_fp(r_s1.sign, '0, '0);

  // Exception resolve: first matching condition wins.
  always_comb begin
    w_result = pack_fp(r_s1.sign, r_s1.exp_r, r_s1.mant_r);
    w_status = make_status(1'b0, 1'b0, 1'b0, r_s1.inexact, 1'b0);
    if (r_s1.nv) begin
      w_result = QNAN_PATTERN;
      w_status = make_status(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end else if (r_s1.of) begin
      w_result = w_inf;
      w_status = make_status(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end else if (r_s1.zr) begin
      w_result = w_zero;
      w_status = make_status(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end else if (r_s1.uf && FLUSH_TO_ZERO) begin
      w_result = w_zero;
      w_status = make_status(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    end else if (r_s1.rnd_ovf) begin
      w_result = w_inf;
      w_status = make_status(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    end
  end

  // Stage 2: packed result; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_status   <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_result;
        r_status <= w_status;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign status    = r_status;

endmodule
